// File: rtl/tl_timing_pkg.sv
// Shared timing constants for the traffic-light controller timebase.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package tl_timing_pkg;

    // Default clock and base tick rates (Hz)
    localparam int unsigned DEF_CLK_HZ  = 74_250_000;
    localparam int unsigned DEF_BASE_HZ = 1_000;

    // Standard periods in base ticks (1 ms each at the default base rate)
    localparam int unsigned T_1HZ    = 1_000;
    localparam int unsigned T_BLINK  = 500;
    localparam int unsigned T_GREEN  = 20_000;
    localparam int unsigned T_YELLOW = 3_000;
    localparam int unsigned T_RED    = 25_000;

    // Integer clock divide ratio from the input clock to the base tick
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned base_hz);
        return clk_hz / base_hz;
    endfunction

    // The divider only works for an exact integer ratio of at least 2
    function automatic logic div_ok(input int unsigned clk_hz,
                                    input int unsigned base_hz);
        return (base_hz != 0) && ((clk_hz % base_hz) == 0) && ((clk_hz / base_hz) >= 2);
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One derived timebase channel: period register, base-tick counter, strobe and square wave.
// Latency: tick/sq registered on the same edge as the prescaler wrap (coincident with base_tick).
// Backpressure: none; tick is a 1-cycle strobe that must be sampled every cycle.
module tick_chan
    import tl_timing_pkg::*;
#(
    parameter int unsigned CW         = 16,
    parameter int unsigned DEF_PERIOD = T_1HZ
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ev,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] period,
    output logic          tick,
    output logic          sq
);

    logic [CW-1:0] per_q;
    logic [CW-1:0] cnt_q;
    logic          at_end;

    // Last count of the period; a zero period never matches so the channel idles
    assign at_end = (per_q != '0) && (cnt_q == (per_q - CW'(1)));

    // Period register: reloaded on load, survives sync clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q <= CW'(DEF_PERIOD);
        end else if (load) begin
            per_q <= period;
        end
    end

    // Counter, strobe and square wave; clear beats load beats the base-tick event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
            sq    <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            tick  <= 1'b0;
            sq    <= 1'b0;
        end else if (load) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (ev && (per_q != '0)) begin
            if (at_end) begin
                cnt_q <= '0;
                tick  <= 1'b1;
                sq    <= ~sq;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Timebase: divides clk to a base tick, then fans out N_CH programmable strobe/square channels.
// Latency: base_tick and ch_tick registered one cycle after the prescaler wrap; first base_tick at cycle DIV.
// Backpressure: none; en freezes the whole timebase, strobes are not held for the consumer.
module tick_gen
    import tl_timing_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
    parameter int unsigned BASE_HZ    = DEF_BASE_HZ,
    parameter int unsigned N_CH       = 3,
    parameter int unsigned CW         = 16,
    parameter int unsigned DEF_PERIOD = T_1HZ
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync_clr,
    input  logic [N_CH*CW-1:0] ch_period,
    input  logic [N_CH-1:0]    ch_load,
    output logic               base_tick,
    output logic [N_CH-1:0]    ch_tick,
    output logic [N_CH-1:0]    ch_sq
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BASE_HZ);
    localparam int unsigned PW  = $clog2(DIV);

    // Elaboration-time parameter sanity
    if (!div_ok(CLK_HZ, BASE_HZ)) begin : g_bad_div
        $error("tick_gen: CLK_HZ must be an exact multiple of BASE_HZ with ratio >= 2");
    end
    if ((N_CH < 1) || (N_CH > 8)) begin : g_bad_nch
        $error("tick_gen: N_CH must be in 1..8");
    end
    if ((CW < 1) || (CW > 31) || (DEF_PERIOD > ((2 ** CW) - 1))) begin : g_bad_cw
        $error("tick_gen: DEF_PERIOD must fit in CW bits");
    end

    logic [PW-1:0] presc_q;
    logic          wrap;

    // Wrap event: last prescaler count while running
    assign wrap = en && (presc_q == PW'(DIV - 1));

    // Prescaler 0..DIV-1, held while en is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (sync_clr) begin
            presc_q <= '0;
        end else if (en) begin
            presc_q <= wrap ? '0 : (presc_q + PW'(1));
        end
    end

    // Base tick strobe, registered from the wrap event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_tick <= 1'b0;
        end else begin
            base_tick <= wrap && !sync_clr;
        end
    end

    // Independent derived channels all driven by the same wrap event
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tick_chan #(
            .CW         (CW),
            .DEF_PERIOD (DEF_PERIOD)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .ev     (wrap),
            .clr    (sync_clr),
            .load   (ch_load[i]),
            .period (ch_period[i*CW +: CW]),
            .tick   (ch_tick[i]),
            .sq     (ch_sq[i])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: directed timing scenarios plus randomized traffic vs a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_tick_gen;

    localparam int CLK_HZ     = 20;
    localparam int BASE_HZ    = 5;
    localparam int DIV        = CLK_HZ / BASE_HZ;
    localparam int N_CH       = 2;
    localparam int CW         = 4;
    localparam int DEF_PERIOD = 3;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               en        = 1'b0;
    logic               sync_clr  = 1'b0;
    logic [N_CH*CW-1:0] ch_period = '0;
    logic [N_CH-1:0]    ch_load   = '0;
    logic               base_tick;
    logic [N_CH-1:0]    ch_tick;
    logic [N_CH-1:0]    ch_sq;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: total enabled cycles since clear, base ticks since channel restart
    int              m_run;
    int              m_bt [N_CH];
    int              m_p  [N_CH];
    logic            m_base;
    logic [N_CH-1:0] m_tick;
    logic [N_CH-1:0] m_sq;

    tick_gen #(
        .CLK_HZ     (CLK_HZ),
        .BASE_HZ    (BASE_HZ),
        .N_CH       (N_CH),
        .CW         (CW),
        .DEF_PERIOD (DEF_PERIOD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sync_clr  (sync_clr),
        .ch_period (ch_period),
        .ch_load   (ch_load),
        .base_tick (base_tick),
        .ch_tick   (ch_tick),
        .ch_sq     (ch_sq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_run  = 0;
        m_base = 1'b0;
        m_tick = '0;
        m_sq   = '0;
        for (int i = 0; i < N_CH; i++) begin
            m_bt[i] = 0;
            m_p[i]  = DEF_PERIOD;
        end
    endtask

    // A base tick happens every DIV enabled cycles; a channel ticks on every P-th base tick
    task automatic model_edge();
        logic w;
        if (sync_clr) begin
            m_run  = 0;
            m_base = 1'b0;
            m_tick = '0;
            m_sq   = '0;
            for (int i = 0; i < N_CH; i++) begin
                m_bt[i] = 0;
                if (ch_load[i]) m_p[i] = int'(ch_period[i*CW +: CW]);
            end
        end else begin
            w = en && (((m_run + 1) % DIV) == 0);
            if (en) m_run++;
            m_base = w;
            for (int i = 0; i < N_CH; i++) begin
                m_tick[i] = 1'b0;
                if (ch_load[i]) begin
                    m_p[i]  = int'(ch_period[i*CW +: CW]);
                    m_bt[i] = 0;
                end else if (w && (m_p[i] != 0)) begin
                    m_bt[i]++;
                    if ((m_bt[i] % m_p[i]) == 0) begin
                        m_tick[i] = 1'b1;
                        m_sq[i]   = ~m_sq[i];
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        en       = 1'b0;
        sync_clr = 1'b0;
        ch_load  = '0;
        ch_period = '0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        vectors++;
        if ({base_tick, ch_tick, ch_sq} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%b exp=%b", {base_tick, ch_tick, ch_sq}, 5'b0);
        end
    endtask

    task automatic test_power_up();
        logic b;
        logic [1:0] t, s;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            cycle();
            b = ((c % DIV) == 0);
            t = ((c == 12) || (c == 24)) ? 2'b11 : 2'b00;
            s = ((c >= 12) && (c < 24)) ? 2'b11 : 2'b00;
            vectors++;
            if ({base_tick, ch_tick, ch_sq} !== {b, t, s}) begin
                miscompares++;
                $display("FAIL power_up cyc=%0d got=%b exp=%b", cyc, {base_tick, ch_tick, ch_sq}, {b, t, s});
            end
            vectors++;
            if ({base_tick, ch_tick, ch_sq} !== {m_base, m_tick, m_sq}) begin
                miscompares++;
                $display("FAIL power_up_model cyc=%0d got=%b exp=%b", cyc, {base_tick, ch_tick, ch_sq}, {m_base, m_tick, m_sq});
            end
        end
    endtask

    task automatic test_load_period1();
        logic b, t1, t0, s1, s0;
        int n1;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 37; c++) begin
            cycle();
            b  = ((c % DIV) == 0);
            t1 = (c >= 8) && ((c % 4) == 0);
            n1 = (c >= 8) ? ((c - 8) / 4 + 1) : 0;
            s1 = ((n1 % 2) != 0);
            t0 = (c >= 12) && ((c % 12) == 0);
            s0 = (((c / 12) % 2) != 0);
            vectors++;
            if ({base_tick, ch_tick, ch_sq} !== {b, t1, t0, s1, s0}) begin
                miscompares++;
                $display("FAIL load_p1 cyc=%0d got=%b exp=%b", cyc, {base_tick, ch_tick, ch_sq}, {b, t1, t0, s1, s0});
            end
            if (c == 5) begin
                ch_load        = 2'b10;
                ch_period[7:4] = 4'd1;
            end else begin
                ch_load = '0;
            end
        end
    endtask

    task automatic test_disable_reload();
        int nb;
        ch_load        = 2'b01;
        ch_period[3:0] = 4'd0;
        for (int k = 1; k <= 20; k++) begin
            cycle();
            ch_load = '0;
            vectors++;
            if ({ch_tick[0], ch_sq[0]} !== 2'b01) begin
                miscompares++;
                $display("FAIL disabled_ch0 cyc=%0d got=%b exp=%b", cyc, {ch_tick[0], ch_sq[0]}, 2'b01);
            end
            vectors++;
            if ({base_tick, ch_tick, ch_sq} !== {m_base, m_tick, m_sq}) begin
                miscompares++;
                $display("FAIL disabled_model cyc=%0d got=%b exp=%b", cyc, {base_tick, ch_tick, ch_sq}, {m_base, m_tick, m_sq});
            end
        end
        ch_load        = 2'b01;
        ch_period[3:0] = 4'd2;
        nb = 0;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            ch_load = '0;
            if ((k > 1) && m_base) nb++;
            vectors++;
            if (ch_tick[0] !== ((k > 1) && m_base && (nb == 2))) begin
                miscompares++;
                $display("FAIL reload_p2 cyc=%0d got=%b exp=%b", cyc, ch_tick[0], ((k > 1) && m_base && (nb == 2)));
            end
            if (nb == 2) break;
        end
        vectors++;
        if (nb != 2) begin
            miscompares++;
            $display("FAIL reload_p2_budget got=%0d exp=%0d", nb, 2);
        end
    endtask

    task automatic test_load_on_wrap();
        for (int k = 0; k < DIV; k++) begin
            if (((m_run + 1) % DIV) == 0) break;
            cycle();
        end
        ch_load        = 2'b01;
        ch_period[3:0] = 4'd2;
        cycle();
        ch_load = '0;
        vectors++;
        if ({base_tick, ch_tick[0]} !== 2'b10) begin
            miscompares++;
            $display("FAIL load_on_wrap cyc=%0d got=%b exp=%b", cyc, {base_tick, ch_tick[0]}, 2'b10);
        end
        for (int k = 1; k <= 8; k++) begin
            cycle();
            vectors++;
            if (ch_tick[0] !== (k == 8)) begin
                miscompares++;
                $display("FAIL load_on_wrap_next k=%0d got=%b exp=%b", k, ch_tick[0], (k == 8));
            end
            vectors++;
            if ({base_tick, ch_tick, ch_sq} !== {m_base, m_tick, m_sq}) begin
                miscompares++;
                $display("FAIL load_on_wrap_model cyc=%0d got=%b exp=%b", cyc, {base_tick, ch_tick, ch_sq}, {m_base, m_tick, m_sq});
            end
        end
    endtask

    task automatic test_pause();
        for (int k = 0; k <= DIV; k++) begin
            if (m_base) break;
            cycle();
        end
        cycle();
        en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            vectors++;
            if ({base_tick, ch_tick} !== 3'b000) begin
                miscompares++;
                $display("FAIL pause_ticks k=%0d got=%b exp=%b", k, {base_tick, ch_tick}, 3'b000);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            vectors++;
            if ({base_tick, ch_tick[1]} !== {(k == 3), (k == 3)}) begin
                miscompares++;
                $display("FAIL resume k=%0d got=%b exp=%b", k, {base_tick, ch_tick[1]}, {(k == 3), (k == 3)});
            end
            vectors++;
            if ({base_tick, ch_tick, ch_sq} !== {m_base, m_tick, m_sq}) begin
                miscompares++;
                $display("FAIL resume_model cyc=%0d got=%b exp=%b", cyc, {base_tick, ch_tick, ch_sq}, {m_base, m_tick, m_sq});
            end
        end
    endtask

    task automatic test_clear_and_reset();
        cycle();
        sync_clr = 1'b1;
        cycle();
        sync_clr = 1'b0;
        vectors++;
        if ({base_tick, ch_tick, ch_sq} !== 5'b0) begin
            miscompares++;
            $display("FAIL sync_clr got=%b exp=%b", {base_tick, ch_tick, ch_sq}, 5'b0);
        end
        for (int k = 1; k <= 4; k++) begin
            cycle();
            vectors++;
            if ({base_tick, ch_tick[1]} !== {(k == 4), (k == 4)}) begin
                miscompares++;
                $display("FAIL after_clr k=%0d got=%b exp=%b", k, {base_tick, ch_tick[1]}, {(k == 4), (k == 4)});
            end
        end
        vectors++;
        if (ch_sq[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_rst_sq1 got=%b exp=%b", ch_sq[1], 1'b1);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({base_tick, ch_tick, ch_sq} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset got=%b exp=%b", {base_tick, ch_tick, ch_sq}, 5'b0);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        cyc   = 0;
        en    = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            cycle();
            vectors++;
            if (ch_tick !== ((c == 12) ? 2'b11 : 2'b00)) begin
                miscompares++;
                $display("FAIL restart_period cyc=%0d got=%b exp=%b", c, ch_tick, ((c == 12) ? 2'b11 : 2'b00));
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            en       = ($urandom_range(0, 9) != 0);
            sync_clr = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N_CH; i++) ch_load[i] = ($urandom_range(0, 19) == 0);
            ch_period = 8'($urandom());
            cycle();
            vectors++;
            if ({base_tick, ch_tick, ch_sq} !== {m_base, m_tick, m_sq}) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {base_tick, ch_tick, ch_sq}, {m_base, m_tick, m_sq});
            end
        end
        en       = 1'b1;
        sync_clr = 1'b0;
        ch_load  = '0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_load_period1();
        test_disable_reload();
        test_load_on_wrap();
        test_pause();
        test_clear_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
